// File: rtl/encoder4_2_queue.sv
// Registered 4-to-2 encoder: latches request strobes into a pending set and emits each one
// as a 2-bit index under a valid/ready handshake (fixed priority or round-robin).
module encoder4_2_queue #(
    parameter bit RR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] I,
    output logic [1:0] S,
    output logic       valid,
    input  logic       ready,
    output logic [3:0] pending,
    output logic       dup
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e     r_state;
    logic [1:0] r_s;
    logic [1:0] r_ptr;
    logic [3:0] r_pending;
    logic       r_dup;

    logic       w_load;
    logic [1:0] w_k;
    logic [3:0] w_load_mask;

    always_comb begin : p_select
        logic [1:0] idx;
        w_k = 2'd0;
        idx = 2'd0;
        if (RR == 1'b0) begin
            for (int i = 0; i < 4; i++) begin
                if (r_pending[i]) w_k = 2'(i);
            end
        end else begin
            // Walk from the farthest candidate down so the nearest one after ptr wins.
            for (int off = 3; off >= 0; off--) begin
                idx = r_ptr + 2'd1 + 2'(off);
                if (r_pending[idx]) w_k = idx;
            end
        end
    end

    always_comb begin
        w_load      = ((r_state == StIdle) || ready) && (r_pending != 4'b0000);
        w_load_mask = w_load ? (4'b0001 << w_k) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_s       <= 2'b00;
            r_ptr     <= 2'd3;
            r_pending <= 4'b0000;
            r_dup     <= 1'b0;
        end else begin
            // A bit loaded this edge and re-requested on I stays set as a fresh request.
            r_pending <= (r_pending & ~w_load_mask) | I;
            r_dup     <= |(I & r_pending & ~w_load_mask);
            case (r_state)
                StIdle: begin
                    if (w_load) begin
                        r_s     <= w_k;
                        r_ptr   <= w_k;
                        r_state <= StHold;
                    end
                end
                StHold: begin
                    if (ready) begin
                        if (w_load) begin
                            r_s   <= w_k;
                            r_ptr <= w_k;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign S       = r_s;
    assign valid   = (r_state == StHold);
    assign pending = r_pending;
    assign dup     = r_dup;

endmodule
